// File: rtl/shift_unit_arbiter_if.sv
// Purpose : one requester's request/response channel to the shift arbiter.
// Latency : n/a (wiring only).
// Backpressure: request uses req_valid/req_ready, response uses rsp_valid/rsp_ready.
// Ports   : req_valid/req_ready/req_data/req_amt/req_op, rsp_valid/rsp_ready/rsp_data.
//           master = requester side, slave = arbiter side.
interface shift_unit_arbiter_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_data;
  logic [4:0]  req_amt;
  logic [1:0]  req_op;   // 00 SLL, 01 SRL, 10 SRA, 11 reserved
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;

  modport master (
    output req_valid, req_data, req_amt, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_data, req_amt, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/shift_unit_arbiter.sv
// Purpose : two-port arbiter/sequencer for a shared 32-bit left barrel shifter (SLL/SRL/SRA).
// Latency : accept -> one EXEC cycle -> registered response (one op per 3 cycles at best).
// Backpressure: response held stable while rsp_ready=0; no new request accepted until it drains.
// Ports   : clk, rst_n (async active-low); port0/port1 requester channels (slave modport);
//           sh_a/sh_b drive the shared shifter, sh_r is its combinational left-shift result.
// Config  : SHIFT_ARB_RR_EN defined -> round-robin grant; undefined -> port 0 fixed priority.
//           RESERVED_OP_SLL=1 -> op 2'b11 runs as SLL; 0 -> op 2'b11 returns the operand.
module shift_unit_arbiter #(
  parameter bit RESERVED_OP_SLL = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  shift_unit_arbiter_if.slave         port0,
  shift_unit_arbiter_if.slave         port1,
  output logic [31:0]                 sh_a,
  output logic [31:0]                 sh_b,
  input  logic [31:0]                 sh_r
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  state_e      state_q, state_d;
  logic        owner_q, owner_d;   // port that owns the in-flight operation
  logic [1:0]  op_q, op_d;
  logic        neg_q, neg_d;       // sign of the latched operand, selects SRA inversion
  logic [31:0] sh_a_q, sh_a_d;
  logic [4:0]  amt_q, amt_d;
  logic [31:0] res_q, res_d;
`ifdef SHIFT_ARB_RR_EN
  logic        last_q, last_d;     // last-served port
`endif

  logic        grant;
  logic [31:0] sel_data;
  logic [4:0]  sel_amt;
  logic [1:0]  sel_op;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    op_d     = op_q;
    neg_d    = neg_q;
    sh_a_d   = sh_a_q;
    amt_d    = amt_q;
    res_d    = res_q;
`ifdef SHIFT_ARB_RR_EN
    last_d   = last_q;
    // Contention goes to the port not served last; a lone valid port always wins.
    grant    = (port0.req_valid && port1.req_valid) ? ~last_q : ~port0.req_valid;
`else
    grant    = ~port0.req_valid;
`endif
    sel_data = grant ? port1.req_data : port0.req_data;
    sel_amt  = grant ? port1.req_amt  : port0.req_amt;
    sel_op   = grant ? port1.req_op   : port0.req_op;

    unique case (state_q)
      IDLE: begin
        if (port0.req_valid || port1.req_valid) begin
          owner_d = grant;
          op_d    = sel_op;
          neg_d   = sel_data[31];
          amt_d   = sel_amt;
          // Right shifts run on the left shifter: reverse in, reverse out.
          // Negative SRA also inverts so the zero fill becomes sign fill.
          unique case (sel_op)
            OP_SRL:  sh_a_d = rev32(sel_data);
            OP_SRA:  sh_a_d = sel_data[31] ? rev32(~sel_data) : rev32(sel_data);
            default: sh_a_d = sel_data;
          endcase
          state_d = EXEC;
        end
      end
      EXEC: begin
        unique case (op_q)
          OP_SLL:  res_d = sh_r;
          OP_SRL:  res_d = rev32(sh_r);
          OP_SRA:  res_d = neg_q ? ~rev32(sh_r) : rev32(sh_r);
          // Reserved op: sh_a_q still holds the untouched operand.
          default: res_d = RESERVED_OP_SLL ? sh_r : sh_a_q;
        endcase
        state_d = RESP;
      end
      RESP: begin
        if (owner_q ? port1.rsp_ready : port0.rsp_ready) begin
          state_d = IDLE;
`ifdef SHIFT_ARB_RR_EN
          last_d  = owner_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      op_q    <= 2'b00;
      neg_q   <= 1'b0;
      sh_a_q  <= 32'd0;
      amt_q   <= 5'd0;
      res_q   <= 32'd0;
`ifdef SHIFT_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      sh_a_q  <= sh_a_d;
      amt_q   <= amt_d;
      res_q   <= res_d;
`ifdef SHIFT_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // Ready is gated by rst_n so nothing is offered while reset is held.
  assign port0.req_ready = rst_n && (state_q == IDLE) && port0.req_valid && !grant;
  assign port1.req_ready = rst_n && (state_q == IDLE) && port1.req_valid &&  grant;

  assign port0.rsp_valid = (state_q == RESP) && !owner_q;
  assign port1.rsp_valid = (state_q == RESP) &&  owner_q;
  assign port0.rsp_data  = res_q;
  assign port1.rsp_data  = res_q;

  assign sh_a = sh_a_q;
  assign sh_b = {27'd0, amt_q};

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Purpose : directed self-checking bench for shift_unit_arbiter with a behavioural shifter.
// Latency : checks the accept -> EXEC -> response timing on every operation.
// Backpressure: holds rsp_ready low for several cycles and checks the response stays put.
module tb_shift_unit_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] sh_a;
  logic [31:0] sh_b;
  logic [31:0] sh_r;
  int          checks = 0;
  int          errors = 0;

  shift_unit_arbiter_if p0 ();
  shift_unit_arbiter_if p1 ();

  shift_unit_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .port0 (p0.slave),
    .port1 (p1.slave),
    .sh_a  (sh_a),
    .sh_b  (sh_b),
    .sh_r  (sh_r)
  );

  // Shared shifter: combinational left shift, zero fill.
  assign sh_r = sh_a << sh_b[4:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? p0.req_ready : p1.req_ready;
  endfunction

  function automatic logic rspv(input int p);
    return (p == 0) ? p0.rsp_valid : p1.rsp_valid;
  endfunction

  function automatic logic [31:0] rspd(input int p);
    return (p == 0) ? p0.rsp_data : p1.rsp_data;
  endfunction

  task automatic drive(input int p, input logic v, input logic [31:0] d,
                       input logic [4:0] a, input logic [1:0] op);
    if (p == 0) begin
      p0.req_valid = v; p0.req_data = d; p0.req_amt = a; p0.req_op = op;
    end else begin
      p1.req_valid = v; p1.req_data = d; p1.req_amt = a; p1.req_op = op;
    end
  endtask

  task automatic set_rsp_ready(input int p, input logic v);
    if (p == 0) p0.rsp_ready = v;
    else        p1.rsp_ready = v;
  endtask

  // One complete transaction on a single port, checking timing and values.
  task automatic do_op(input int p, input logic [31:0] d, input logic [4:0] a,
                       input logic [1:0] op, input logic [31:0] exp_sh_a,
                       input logic [31:0] exp, input string tag);
    int n;
    @(negedge clk);
    drive(p, 1'b1, d, a, op);
    #1;
    n = 0;
    while (!rdy(p) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check({tag, "_grant"}, rdy(p), 1'b1);
    @(posedge clk); #1;
    drive(p, 1'b0, 32'd0, 5'd0, 2'b00);
    @(negedge clk);
    check({tag, "_exec_rspv"}, rspv(p), 1'b0);
    check({tag, "_sh_a"}, sh_a, exp_sh_a);
    check({tag, "_sh_b"}, sh_b, {27'd0, a});
    @(negedge clk);
    check({tag, "_rspv"}, rspv(p), 1'b1);
    check({tag, "_data"}, rspd(p), exp);
    check({tag, "_other_rspv"}, rspv(1 - p), 1'b0);
    set_rsp_ready(p, 1'b1);
    @(negedge clk);
    check({tag, "_rspv_drop"}, rspv(p), 1'b0);
    set_rsp_ready(p, 1'b0);
  endtask

  initial begin : stim
    int exp_order [4];
    int g;
    int n;

`ifdef SHIFT_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif

    // Reset with both ports requesting: nothing may be offered.
    rst_n = 1'b0;
    drive(0, 1'b1, 32'h1, 5'd1, 2'b00);
    drive(1, 1'b1, 32'h1, 5'd2, 2'b00);
    p0.rsp_ready = 1'b0;
    p1.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_rdy0", p0.req_ready, 1'b0);
    check("rst_rdy1", p1.req_ready, 1'b0);
    check("rst_rspv0", p0.rsp_valid, 1'b0);
    check("rst_rspv1", p1.rsp_valid, 1'b0);
    check("rst_rspd", p0.rsp_data, 32'd0);
    check("rst_sh_a", sh_a, 32'd0);
    check("rst_sh_b", sh_b, 32'd0);
    drive(0, 1'b0, 32'd0, 5'd0, 2'b00);
    drive(1, 1'b0, 32'd0, 5'd0, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-port directed operations.
    do_op(0, 32'h0000_0001, 5'd4,  2'b00, 32'h0000_0001, 32'h0000_0010, "sll1x4");
    do_op(1, 32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, 32'h0000_0001, "srl_msb31");
    do_op(0, 32'h8000_0000, 5'd4,  2'b10, 32'hFFFF_FFFE, 32'hF800_0000, "sra_neg4");
    do_op(1, 32'h7FFF_FFF0, 5'd4,  2'b10, 32'h0FFF_FFFE, 32'h07FF_FFFF, "sra_pos4");
    do_op(0, 32'hFFFF_FFFF, 5'd0,  2'b10, 32'h0000_0000, 32'hFFFF_FFFF, "sra_amt0");
    do_op(1, 32'h0000_0003, 5'd2,  2'b11, 32'h0000_0003, 32'h0000_000C, "rsvd_sll");
    do_op(0, 32'hDEAD_BEEF, 5'd0,  2'b01, 32'hF77D_B57B, 32'hDEAD_BEEF, "srl_amt0");
    do_op(1, 32'h8000_0001, 5'd31, 2'b10, 32'h7FFF_FFFE, 32'hFFFF_FFFF, "sra_neg31");

    // Both ports continuously valid, straight out of reset.
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 1'b1, 32'h1, 5'd1, 2'b00);
    drive(1, 1'b1, 32'h1, 5'd2, 2'b00);
    p0.rsp_ready = 1'b1;
    p1.rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      g = -1;
      n = 0;
      #1;
      if (p0.req_ready && !p1.req_ready) g = 0;
      else if (p1.req_ready && !p0.req_ready) g = 1;
      while (g < 0 && n < 20) begin
        @(negedge clk); #1;
        if (p0.req_ready && !p1.req_ready) g = 0;
        else if (p1.req_ready && !p0.req_ready) g = 1;
        n++;
      end
      check($sformatf("both_grant%0d", k), g, exp_order[k]);
      n = 0;
      do begin
        @(negedge clk); #1; n++;
      end while (!rspv(exp_order[k]) && n < 10);
      check($sformatf("both_rspv%0d", k), rspv(exp_order[k]), 1'b1);
      check($sformatf("both_data%0d", k), rspd(exp_order[k]),
            (exp_order[k] == 0) ? 32'h2 : 32'h4);
    end
    @(negedge clk);
    drive(0, 1'b0, 32'd0, 5'd0, 2'b00);
    drive(1, 1'b0, 32'd0, 5'd0, 2'b00);
    p0.rsp_ready = 1'b0;
    p1.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Backpressure on port 0 while port 1 waits.
    drive(0, 1'b1, 32'h5, 5'd1, 2'b00);
    drive(1, 1'b1, 32'h1, 5'd3, 2'b00);
    #1;
    check("bp_grant0", p0.req_ready, 1'b1);
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!p0.rsp_valid && n < 10);
    drive(0, 1'b0, 32'd0, 5'd0, 2'b00);
    for (int k = 0; k < 5; k++) begin
      check("bp_rspv0", p0.rsp_valid, 1'b1);
      check("bp_data0", p0.rsp_data, 32'hA);
      check("bp_rdy0", p0.req_ready, 1'b0);
      check("bp_rdy1", p1.req_ready, 1'b0);
      @(negedge clk); #1;
    end
    p0.rsp_ready = 1'b1;
    @(negedge clk); #1;
    check("bp_release_rspv0", p0.rsp_valid, 1'b0);
    check("bp_release_idle", p1.req_ready, 1'b1);
    p0.rsp_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!p1.rsp_valid && n < 10);
    drive(1, 1'b0, 32'd0, 5'd0, 2'b00);
    check("bp_p1_rspv", p1.rsp_valid, 1'b1);
    check("bp_p1_data", p1.rsp_data, 32'h8);
    p1.rsp_ready = 1'b1;
    @(negedge clk);
    p1.rsp_ready = 1'b0;

    // Reset during EXEC aborts the operation.
    @(negedge clk);
    drive(0, 1'b1, 32'h1, 5'd1, 2'b00);
    #1;
    check("abort_grant", p0.req_ready, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'd0, 5'd0, 2'b00);
    @(negedge clk);
    check("abort_exec_sh_b", sh_b, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_rspv0", p0.rsp_valid, 1'b0);
    check("abort_rspv1", p1.rsp_valid, 1'b0);
    check("abort_sh_a", sh_a, 32'd0);
    check("abort_sh_b", sh_b, 32'd0);
    check("abort_rspd", p0.rsp_data, 32'd0);
    p0.rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      check("abort_no_rsp", p0.rsp_valid, 1'b0);
    end
    p0.rsp_ready = 1'b0;
    do_op(0, 32'h1234_5678, 5'd8, 2'b01, 32'h1E6A_2C48, 32'h0012_3456, "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
